// File: rtl/ulpi_reg_access.sv
// ULPI register read/write engine for the USB3300 link side, with PHY-abort retry and NXT timeout.
// Define ULPI_EXT_ADDR_EN to compile in extended-address accesses (EXTADDR state).
module ulpi_reg_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETRY_MAX      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       REQ,
  input  logic       WE,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  input  logic       DIR,
  output logic       STP,
  input  logic       NXT,
  input  logic [7:0] ULPI_DATA_IN,
  output logic [7:0] ULPI_DATA_OUT,
  output logic       ULPI_OE
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_TXCMD,
`ifdef ULPI_EXT_ADDR_EN
    S_EXTADDR,
`endif
    S_WDATA,
    S_STOP,
    S_TURN1,
    S_RDATA,
    S_TURN2,
    S_FINISH
  } state_t;

  state_t          state;
  logic [RW-1:0]   retry_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      rdata_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            stp_q;
  logic [7:0]      dout_q;
  logic            oe_q;

  // Request latch and read holding register carry data only, so they are not reset.
  logic            we_q;
  logic [5:0]      cmd_a_q;
  logic [7:0]      wdata_q;
  logic [7:0]      hold_q;
`ifdef ULPI_EXT_ADDR_EN
  logic            ext_q;
  logic [7:0]      addr_q;
`else
  logic            unused_addr_hi;
  assign unused_addr_hi = ^ADDR[7:6];
`endif

  function automatic logic [7:0] txcmd_byte(input logic we, input logic [5:0] a);
    return {1'b1, ~we, a};
  endfunction

`ifdef ULPI_EXT_ADDR_EN
  function automatic logic is_ext(input logic [7:0] a);
    return (a[7:6] != 2'b00) || (a[5:0] == 6'h2F);
  endfunction
`endif

  logic link_phase;
  logic abort;

  assign link_phase = (state == S_TXCMD) || (state == S_WDATA)
`ifdef ULPI_EXT_ADDR_EN
                      || (state == S_EXTADDR)
`endif
                      ;
  assign abort = (link_phase && DIR) || (state == S_RDATA && DIR && NXT);

  always_ff @(posedge clk) begin
    if (state == S_IDLE && REQ) begin
      we_q    <= WE;
      wdata_q <= WDATA;
`ifdef ULPI_EXT_ADDR_EN
      ext_q   <= is_ext(ADDR);
      addr_q  <= ADDR;
      cmd_a_q <= is_ext(ADDR) ? 6'h2F : ADDR[5:0];
`else
      cmd_a_q <= ADDR[5:0];
`endif
    end
    if (state == S_RDATA && DIR && !NXT) hold_q <= ULPI_DATA_IN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stp_q     <= 1'b0;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
    end else if (abort) begin
      // PHY took the bus: release it and retry, unless the retry budget is spent
      oe_q      <= 1'b0;
      dout_q    <= 8'h00;
      tmo_cnt   <= '0;
      retry_cnt <= retry_cnt + 1'b1;
      if (retry_cnt == RETRY_LAST) begin
        state  <= S_FINISH;
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end else begin
        state  <= S_ARB;
      end
    end else if (link_phase && !NXT) begin
      if (tmo_cnt == TMO_LAST) begin
        oe_q    <= 1'b0;
        dout_q  <= 8'h00;
        tmo_cnt <= '0;
        state   <= S_FINISH;
        done_q  <= 1'b1;
        err_q   <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ) begin
            busy_q    <= 1'b1;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            state     <= S_ARB;
          end
        end
        S_ARB: begin
          if (!DIR) begin
            dout_q <= txcmd_byte(we_q, cmd_a_q);
            oe_q   <= 1'b1;
            state  <= S_TXCMD;
          end
        end
        S_TXCMD: begin
          tmo_cnt <= '0;
`ifdef ULPI_EXT_ADDR_EN
          if (ext_q) begin
            dout_q <= addr_q;
            state  <= S_EXTADDR;
          end else
`endif
          if (we_q) begin
            dout_q <= wdata_q;
            state  <= S_WDATA;
          end else begin
            oe_q   <= 1'b0;
            dout_q <= 8'h00;
            state  <= S_TURN1;
          end
        end
`ifdef ULPI_EXT_ADDR_EN
        S_EXTADDR: begin
          tmo_cnt <= '0;
          if (we_q) begin
            dout_q <= wdata_q;
            state  <= S_WDATA;
          end else begin
            oe_q   <= 1'b0;
            dout_q <= 8'h00;
            state  <= S_TURN1;
          end
        end
`endif
        S_WDATA: begin
          tmo_cnt <= '0;
          stp_q   <= 1'b1;
          dout_q  <= 8'h00;
          state   <= S_STOP;
        end
        S_STOP: begin
          stp_q  <= 1'b0;
          oe_q   <= 1'b0;
          done_q <= 1'b1;
          err_q  <= 1'b0;
          state  <= S_FINISH;
        end
        S_TURN1: begin
          if (DIR) begin
            state <= S_RDATA;
          end else begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= S_FINISH;
          end
        end
        S_RDATA: begin
          if (DIR) begin
            state <= S_TURN2;
          end else begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= S_FINISH;
          end
        end
        S_TURN2: begin
          if (!DIR) begin
            rdata_q <= hold_q;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state   <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // DIR gates the bus drivers combinationally so the link never fights the PHY.
  assign ULPI_OE       = oe_q & ~DIR;
  assign ULPI_DATA_OUT = DIR ? 8'h00 : dout_q;
  assign RDATA         = rdata_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign STP           = stp_q;

  a_err_only_with_done: assert property (@(posedge clk) disable iff (!rst) ERR |-> DONE);
  a_done_while_busy:    assert property (@(posedge clk) disable iff (!rst) DONE |-> BUSY);

endmodule

// File: doc/ulpi_reg_access.md
# ulpi_reg_access

Parametrised ULPI register-access engine for the USB3300 link side. It performs both register writes and register reads, including ULPI extended-address accesses. It tolerates PHY aborts (DIR rising mid-command) by retrying, and bounds every NXT wait with a timeout. It sits between the sniffer's ULPI controller and the ULPI pins, owning the bus only while BUSY is high.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive cycles the link waits for NXT in any link-driven phase before it flags an error.
- RETRY_MAX, 3: number of PHY aborts tolerated per request; the next abort ends the request with ERR.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock (ULPI 60 MHz).
- rst  in  1  asynchronous, active-low reset.
- REQ  in  1  start request; sampled only while BUSY=0.
- WE  in  1  1 = write, 0 = read; latched with REQ.
- ADDR  in  8  register address; latched with REQ.
- WDATA  in  8  write data; latched with REQ.
- RDATA  out  8  last successfully read value.
- BUSY  out  1  high from the cycle after REQ is accepted until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse coincident with DONE when the request failed.
- DIR  in  1  ULPI DIR.
- STP  out  1  ULPI STP.
- NXT  in  1  ULPI NXT.
- ULPI_DATA_IN  in  8  ULPI data from the PHY.
- ULPI_DATA_OUT  out  8  ULPI data driven by the link.
- ULPI_OE  out  1  1 = link drives the data bus.

## Operation
- States: IDLE, ARB, TXCMD, EXTADDR, WDATA, STOP, TURN1, RDATA, TURN2, FINISH.
- IDLE: REQ=1 latches WE, ADDR and WDATA, clears the retry and timeout counters, and moves to ARB.
- ARB: waits for DIR=0, then loads the TXCMD into ULPI_DATA_OUT, sets ULPI_OE=1 and moves to TXCMD.
- TXCMD byte: write uses {2'b10, a}, read uses {2'b11, a}. The field a is ADDR[5:0] for an immediate access and 6'h2F for an extended access.
- Extended access: taken when ADDR[7:6]!=0 or ADDR[5:0]==6'h2F, and only if extended addressing is compiled in.
- TXCMD: holds the byte until NXT=1. It then loads the next byte and moves on:
  - extended access: loads ADDR and goes to EXTADDR;
  - write: loads WDATA and goes to WDATA;
  - read: goes to TURN1.
- EXTADDR: holds ADDR until NXT=1, then moves to WDATA (write) or TURN1 (read).
- WDATA: holds WDATA until NXT=1, then goes to STOP.
- STOP: STP=1 and ULPI_DATA_OUT=0 for exactly one cycle, then ULPI_OE=0 and FINISH.
- TURN1: ULPI_OE=0, ULPI_DATA_OUT=0.
  - DIR=1: go to RDATA.
  - DIR=0: ERR path.
- RDATA:
  - DIR=1, NXT=0: capture ULPI_DATA_IN into a holding register and go to TURN2.
  - DIR=1, NXT=1: RXCMD interrupt; treat as an abort.
  - DIR=0: ERR path.
- TURN2: waits for DIR=0, commits the holding register to RDATA, then FINISH.
- FINISH: DONE=1 (ERR as determined) for one cycle, then IDLE.
- Abort: DIR=1 while in TXCMD, EXTADDR or WDATA.
  - The link drops ULPI_OE and clears ULPI_DATA_OUT in the same cycle, combinationally gated by DIR.
  - The retry counter increments and the request returns to ARB.
  - If the count reaches RETRY_MAX+1, the request goes to FINISH with ERR=1 instead.
- Timeout: the counter increments each cycle NXT=0 in TXCMD, EXTADDR or WDATA, and clears whenever NXT=1 or the phase changes. Reaching TIMEOUT_CYCLES sends the request to FINISH with ERR=1 and ULPI_OE=0.
- Error completion: RDATA is not updated on any ERR completion.
- REQ while BUSY=1: ignored.

## Timing
- Reset values: RDATA=0, BUSY=0, DONE=0, ERR=0, STP=0, ULPI_DATA_OUT=0, ULPI_OE=0. State is IDLE and both counters are 0.
- All outputs are registered, except the DIR gating of ULPI_OE and ULPI_DATA_OUT.
- Reset mid-operation returns to IDLE immediately and releases the bus. No DONE is issued.
- Immediate write with NXT answered on the first cycle of each byte: REQ at cycle 0; TXCMD on the bus at cycle 2; WDATA at cycle 3; STP at cycle 4; DONE at cycle 5.
- Immediate read with a compliant PHY: TXCMD at cycle 2, NXT at cycle 2, turnaround at cycle 3, data at cycle 4, DIR low at cycle 5, DONE at cycle 6.
- BUSY is high from the cycle after REQ through the DONE cycle inclusive.
- DONE and ERR are never high outside FINISH.

## Configuration
- ULPI_EXT_ADDR_EN defined: extended-address accesses are supported and the EXTADDR state exists.
- ULPI_EXT_ADDR_EN undefined: ADDR[7:6] is ignored and EXTADDR is removed. ADDR[5:0]==6'h2F is sent as an immediate access.

## Test plan
- Immediate write ADDR=8'h04, WDATA=8'h45, NXT answered immediately:
  - required: bus carries 8'h84 then 8'h45;
  - STP pulses for one cycle; DONE=1 with ERR=0.
- Immediate read ADDR=8'h0A, PHY returns 8'h5C: TXCMD=8'hCA; RDATA=8'h5C at DONE; ERR=0.
- Extended read ADDR=8'h81 with ULPI_EXT_ADDR_EN defined: bus carries 8'hEF then 8'h81; RDATA updated. Without the macro: TXCMD=8'hC1.
- DIR raised during TXCMD twice, then a clean access with RETRY_MAX=3:
  - required: ULPI_OE drops in the abort cycle each time;
  - the request retries and completes with ERR=0.
- NXT held at 0 with TIMEOUT_CYCLES=16: DONE with ERR=1 after 16 TXCMD cycles; ULPI_OE=0; RDATA unchanged.
- rst asserted in WDATA: outputs return to reset values asynchronously; no DONE; a following REQ completes normally.
